// File: rtl/csr_unit_if.sv
// Request/write-back bus between decode and the CSR execute unit.
// Decode drives a CSR instruction in; the unit returns a registered write-back.
interface csr_unit_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic [2:0]      funct3_i;
  logic [11:0]     csr_addr_i;
  logic [4:0]      src_idx_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [4:0]      rd_i;

  logic            rd_we_o;
  logic [4:0]      rd_o;
  logic [XLEN-1:0] rd_data_o;
  logic            illegal_o;

  modport master (
    output valid_i, funct3_i, csr_addr_i, src_idx_i, rs1_data_i, rd_i,
    input  rd_we_o, rd_o, rd_data_o, illegal_o
  );

  modport slave (
    input  valid_i, funct3_i, csr_addr_i, src_idx_i, rs1_data_i, rd_i,
    output rd_we_o, rd_o, rd_data_o, illegal_o
  );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file with atomic csrrw/rs/rc(i), 64-bit cycle/instret
// counters, illegal-access detection and trap-entry / mret state updates.
module csr_unit #(
  parameter int              XLEN         = 32,
  parameter bit              HAS_COUNTERS = 1'b1,
  parameter logic [XLEN-1:0] MTVEC_RESET  = '0
) (
  input  logic            clk,
  input  logic            rst,
  csr_unit_if.slave       req,
  input  logic            retire_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] trap_vec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mie_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH= 12'hB82;
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
  localparam logic [11:0] ADDR_INSTRETH = 12'hC82;

  localparam logic [XLEN-1:0] LOW2_MASK = ~XLEN'(3);

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_MSTATUS,
    SEL_MTVEC,
    SEL_MSCRATCH,
    SEL_MEPC,
    SEL_MCAUSE,
    SEL_CYC_LO,
    SEL_CYC_HI,
    SEL_INS_LO,
    SEL_INS_HI
  } csr_sel_e;

  // Architectural state
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [63:0]     mcycle_q, mcycle_d;
  logic [63:0]     minstret_q, minstret_d;

  // Registered write-back
  logic            rd_we_q, rd_we_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            illegal_q, illegal_d;

  // Request decode
  csr_sel_e        sel;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] new_val;
  logic            wr_intent;
  logic            illegal;
  logic            do_op;
  logic            csr_we;

  // Shadow addresses alias their machine counterparts; read-only-ness is
  // enforced separately by the addr[11:10] check.
  always_comb begin
    sel = SEL_NONE;
    case (req.csr_addr_i)
      ADDR_MSTATUS:                 sel = SEL_MSTATUS;
      ADDR_MTVEC:                   sel = SEL_MTVEC;
      ADDR_MSCRATCH:                sel = SEL_MSCRATCH;
      ADDR_MEPC:                    sel = SEL_MEPC;
      ADDR_MCAUSE:                  sel = SEL_MCAUSE;
      ADDR_MCYCLE,   ADDR_CYCLE:    if (HAS_COUNTERS) sel = SEL_CYC_LO;
      ADDR_MINSTRET, ADDR_INSTRET:  if (HAS_COUNTERS) sel = SEL_INS_LO;
      ADDR_MCYCLEH,  ADDR_CYCLEH:   if (HAS_COUNTERS && XLEN == 32) sel = SEL_CYC_HI;
      ADDR_MINSTRETH,ADDR_INSTRETH: if (HAS_COUNTERS && XLEN == 32) sel = SEL_INS_HI;
      default:                      sel = SEL_NONE;
    endcase
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    old_val = '0;
    case (sel)
      SEL_MSTATUS: begin
        old_val[3] = mie_q;
        old_val[7] = mpie_q;
      end
      SEL_MTVEC:    old_val = mtvec_q;
      SEL_MSCRATCH: old_val = mscratch_q;
      SEL_MEPC:     old_val = mepc_q;
      SEL_MCAUSE:   old_val = mcause_q;
      SEL_CYC_LO:   old_val = mcycle_q[XLEN-1:0];
      SEL_CYC_HI:   old_val = XLEN'(mcycle_q[63:32]);
      SEL_INS_LO:   old_val = minstret_q[XLEN-1:0];
      SEL_INS_HI:   old_val = XLEN'(minstret_q[63:32]);
      default:      old_val = '0;
    endcase
  end

  always_comb begin
    src = req.funct3_i[2] ? XLEN'(req.src_idx_i) : req.rs1_data_i;
    case (req.funct3_i[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = old_val;
    endcase
    wr_intent = (req.funct3_i[1:0] == 2'b01) || (req.src_idx_i != 5'd0);
    illegal   = (req.funct3_i[1:0] == 2'b00) || (sel == SEL_NONE) ||
                (wr_intent && req.csr_addr_i[11:10] == 2'b11);
    // Trap and mret own the cycle; a coinciding CSR op is dropped silently.
    do_op     = req.valid_i && !trap_i && !mret_i;
    csr_we    = do_op && !illegal && wr_intent;
  end

  // Counters: a written half takes the written value, the other half holds.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, retire_i};
    if (csr_we && sel == SEL_CYC_LO) begin
      if (XLEN == 32) mcycle_d = {mcycle_q[63:32], new_val[31:0]};
      else            mcycle_d = 64'(new_val);
    end else if (csr_we && sel == SEL_CYC_HI) begin
      mcycle_d = {new_val[31:0], mcycle_q[31:0]};
    end
    if (csr_we && sel == SEL_INS_LO) begin
      if (XLEN == 32) minstret_d = {minstret_q[63:32], new_val[31:0]};
      else            minstret_d = 64'(new_val);
    end else if (csr_we && sel == SEL_INS_HI) begin
      minstret_d = {new_val[31:0], minstret_q[31:0]};
    end
    if (!HAS_COUNTERS) begin
      mcycle_d   = '0;
      minstret_d = '0;
    end
  end

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (trap_i) begin
      mepc_d   = trap_pc_i & LOW2_MASK;
      mcause_d = trap_cause_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_i) begin
      mie_d    = mpie_q;
      mpie_d   = 1'b1;
    end else if (csr_we) begin
      case (sel)
        SEL_MSTATUS: begin
          mie_d  = new_val[3];
          mpie_d = new_val[7];
        end
        SEL_MTVEC:    mtvec_d    = new_val & LOW2_MASK;
        SEL_MSCRATCH: mscratch_d = new_val;
        SEL_MEPC:     mepc_d     = new_val & LOW2_MASK;
        SEL_MCAUSE:   mcause_d   = new_val;
        default:      ;
      endcase
    end
  end

  always_comb begin
    rd_we_d   = do_op && !illegal && (req.rd_i != 5'd0);
    illegal_d = do_op && illegal;
    rd_d      = do_op ? req.rd_i : rd_q;
    rd_data_d = do_op ? old_val  : rd_data_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET & LOW2_MASK;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
      rd_we_q    <= 1'b0;
      rd_q       <= '0;
      rd_data_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      rd_we_q    <= rd_we_d;
      rd_q       <= rd_d;
      rd_data_q  <= rd_data_d;
      illegal_q  <= illegal_d;
    end
  end

  assign req.rd_we_o   = rd_we_q;
  assign req.rd_o      = rd_q;
  assign req.rd_data_o = rd_data_q;
  assign req.illegal_o = illegal_q;
  assign trap_vec_o    = {mtvec_q[XLEN-1:2], 2'b00};
  assign mepc_o        = mepc_q;
  assign mie_o         = mie_q;

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Parametrised successor to the combinational CSR execute stage: owns the machine-mode CSR storage and performs csrrw/csrrs/csrrc and their immediate forms as an atomic read-modify-write.
- Produces a registered write-back, free-running cycle and instret counters, illegal-access detection, and trap-entry/mret state updates.
- Sits in EX, fed by decode; its write-back output goes to the register-file write port, and trap_vec_o/mepc_o go to the fetch redirect logic.

Parameters:
XLEN, 32, data width (32 or 64); sets counter-high CSR legality.
HAS_COUNTERS, 1, 0 removes mcycle/minstret storage; counter addresses become illegal.
MTVEC_RESET, 0, reset value of mtvec (low 2 bits forced 0).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_i  in  1  CSR instruction present this cycle
funct3_i  in  3  001 rw, 010 rs, 011 rc, 101 rwi, 110 rsi, 111 rci
csr_addr_i  in  12  CSR address (inst[31:20])
src_idx_i  in  5  rs1 index / zimm (inst[19:15])
rs1_data_i  in  XLEN  rs1 operand
rd_i  in  5  destination register
retire_i  in  1  one instruction retired this cycle
trap_i  in  1  take trap this cycle
trap_cause_i  in  XLEN  mcause value on trap
trap_pc_i  in  XLEN  faulting PC
mret_i  in  1  mret executing
rd_we_o  out  1  registered write-back enable
rd_o  out  5  registered destination
rd_data_o  out  XLEN  registered old CSR value
illegal_o  out  1  registered illegal-instruction flag
trap_vec_o  out  XLEN  {mtvec[XLEN-1:2],2'b00}, combinational
mepc_o  out  XLEN  current mepc
mie_o  out  1  mstatus.MIE

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: only MIE bit3 and MPIE bit7 are writable; all other bits read 0.
  - mtvec 0x305: bits[1:0] read 0.
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342.
  - mcycle 0xB00, minstret 0xB02.
  - Read-only shadows cycle 0xC00, instret 0xC02.
  - When XLEN=32: mcycleh 0xB80, minstreth 0xB82, cycleh 0xC80, instreth 0xC82.
- Operand: src = rs1_data_i for funct3[2]=0; src = zero-extended src_idx_i for funct3[2]=1.
- New value:
  - rw/rwi: src.
  - rs/rsi: old | src.
  - rc/rci: old & ~src.
- Write intent:
  - rw/rwi: always.
  - rs/rc/rsi/rci: only when src_idx_i != 0.
- Illegal (illegal_o=1, no CSR write, rd_we_o=0) if any of:
  - funct3 is 000 or 100;
  - address is unimplemented;
  - write intent to an address with addr[11:10]=2'b11.
- Latency: the request is sampled on the edge where valid_i=1. On that same edge the CSR is written and rd_data_o/rd_o/illegal_o are registered.
  - rd_we_o=1 for one cycle iff legal and rd_i!=0.
  - The CSR side effect still occurs when rd_i=0.
- Back-to-back: every cycle may carry a request. The second request reads the value written by the first (no forwarding hazard, since the write lands at the same edge).
- Counters:
  - 64-bit.
  - mcycle increments by 1 every cycle rst=0.
  - minstret increments by 1 when retire_i=1.
  - A CSR write to any half replaces that half, and the written half takes the written value with no increment that cycle. The other half holds.
  - Wrap from all-ones to 0 silently.
- Trap (trap_i=1):
  - mepc <= trap_pc_i with bits[1:0]=0.
  - mcause <= trap_cause_i.
  - MPIE <= MIE.
  - MIE <= 0.
- mret (mret_i=1, trap_i=0): MIE <= MPIE, MPIE <= 1.
- Priority in one cycle: trap_i > mret_i > CSR op.
  - A CSR op coinciding with trap_i or mret_i is squashed: no write, rd_we_o=0, illegal_o=0.
  - Counter increments still apply.
- Reset (rst=1):
  - All CSRs clear to 0, except mtvec=MTVEC_RESET & ~3.
  - Outputs: rd_we_o=0, rd_o=0, rd_data_o=0, illegal_o=0.
  - Reset overrides any in-flight request; there is no counting during reset.
- valid_i=0: rd_we_o=0 and illegal_o=0 next cycle; rd_data_o/rd_o hold.

Test Plan:
- Reset, then csrrw mscratch with rs1_data=0xDEADBEEF, rd=5 -> next cycle rd_we_o=1, rd_o=5, rd_data_o=0. A following csrrs mscratch with src_idx=0, rd=6 returns 0xDEADBEEF with no write.
- mscratch=0xF0F0; csrrci imm 0x10, then csrrsi imm 0x01 -> reads return 0xF0F0 then 0xF0E0; final value 0xF0E1.
- csrrw to cycle 0xC00 -> illegal_o=1, rd_we_o=0, mcycle unaffected. csrrs cycle with src_idx=0 -> legal read. funct3=100 -> illegal.
- Write mcycle=0xFFFFFFFF (XLEN=32), then hold 2 idle cycles -> mcycle=0x1, mcycleh=1. A write to mcycle coinciding with an increment yields the written value.
- MIE=1; trap_i with cause 0xB, pc 0x1003 -> mepc=0x1000, mcause=0xB, MPIE=1, MIE=0. A same-cycle csrrw is squashed. mret -> MIE=1, MPIE=1.
- Assert rst mid-stream with valid_i=1 -> all outputs 0 next cycle; mtvec=MTVEC_RESET & ~3.
